// File: rtl/rock_drive.sv
// rock_drive: pendulum-style rocking motor driver.
// Prescaled swing timer with apex-sampled frequency/amplitude commands and 4-bit PWM.
module rock_drive #(
   parameter int PRESCALE = 1000,
   parameter int HP_INIT  = 100,
   parameter int HP_MIN   = 20,
   parameter int HP_MAX   = 200,
   parameter int HP_STEP  = 10,
   parameter int AMP_INIT = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       Fplus,
   input  logic       Fmin,
   input  logic       Amin,
   output logic       motorDir,
   output logic       motorPwm,
   output logic       apex,
   output logic       Flow,
   output logic [7:0] halfPeriod,
   output logic [3:0] amp
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
   localparam logic [8:0] HP_MIN9  = 9'(HP_MIN);
   localparam logic [8:0] HP_MAX9  = 9'(HP_MAX);
   localparam logic [8:0] HP_STEP9 = 9'(HP_STEP);
   localparam logic [7:0] HP_MIN8  = 8'(HP_MIN);
   localparam logic [7:0] HP_MAX8  = 8'(HP_MAX);
   localparam logic [7:0] HP_STEP8 = 8'(HP_STEP);
   localparam logic [7:0] HP_INIT8 = 8'(HP_INIT);
   localparam logic [3:0] AMP_INIT4 = 4'(AMP_INIT);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    swing_q, swing_d;
   logic [7:0]    hp_q, hp_d;
   logic [3:0]    amp_q, amp_d;
   logic [3:0]    pwm_q, pwm_d;
   logic          dir_q, dir_d;
   logic          apex_q, apex_d;

   logic          tick;
   logic          apex_edge;
   logic [8:0]    hp_wide;
   logic [7:0]    hp_up;
   logic [7:0]    hp_dn;

   // Tick from the prescaler; apex edge on the last tick of a half-swing.
   always_comb begin
      tick      = (presc_q == PS_LAST);
      apex_edge = tick && (swing_q == hp_q - 8'd1);
   end

   // Saturating half-period candidates; compares done 9 bits wide so they never wrap.
   always_comb begin
      hp_wide = {1'b0, hp_q};
      hp_up   = (hp_wide + HP_STEP9 > HP_MAX9) ? HP_MAX8 : hp_q + HP_STEP8;
      hp_dn   = (hp_wide < HP_MIN9 + HP_STEP9) ? HP_MIN8 : hp_q - HP_STEP8;
   end

   // Next-state logic: counters, apex commands, then start override on top.
   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      swing_d = swing_q;
      hp_d    = hp_q;
      amp_d   = amp_q;
      dir_d   = dir_q;
      apex_d  = 1'b0;
      pwm_d   = pwm_q + 4'd1;

      if (tick) begin
         swing_d = apex_edge ? 8'd0 : swing_q + 8'd1;
      end

      if (apex_edge) begin
         dir_d  = ~dir_q;
         apex_d = 1'b1;
         case ({Fplus, Fmin})
            2'b10:   hp_d = hp_dn;
            2'b01:   hp_d = hp_up;
            default: hp_d = hp_q;
         endcase
         if (Amin && (amp_q != 4'd0)) begin
            amp_d = amp_q - 4'd1;
         end
      end

      if (start) begin
         presc_d = '0;
         swing_d = 8'd0;
         hp_d    = hp_q;
         amp_d   = AMP_INIT4;
         dir_d   = 1'b0;
         apex_d  = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         swing_q <= 8'd0;
         hp_q    <= HP_INIT8;
         amp_q   <= 4'd0;
         pwm_q   <= 4'd0;
         dir_q   <= 1'b0;
         apex_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         swing_q <= swing_d;
         hp_q    <= hp_d;
         amp_q   <= amp_d;
         pwm_q   <= pwm_d;
         dir_q   <= dir_d;
         apex_q  <= apex_d;
      end
   end

   assign motorDir   = dir_q;
   assign apex       = apex_q;
   assign halfPeriod = hp_q;
   assign amp        = amp_q;
   assign Flow       = (amp_q != 4'd0);
   assign motorPwm   = (pwm_q < amp_q);

endmodule

// File: doc/rock_drive.md
ROCK_DRIVE -- requirements
Module: rock_drive

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  PRESCALE  1000  clk cycles per swing tick
  HP_INIT  100  half-period in ticks after reset
  HP_MIN  20  lower saturation of half-period
  HP_MAX  200  upper saturation of half-period
  HP_STEP  10  half-period change per frequency command
  AMP_INIT  12  amplitude loaded by start
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  synchronous; (re)starts rocking at AMP_INIT
  Fplus  in  1  raise rocking frequency (shorten half-period)
  Fmin  in  1  lower rocking frequency (lengthen half-period)
  Amin  in  1  lower amplitude by one step
  motorDir  out  1  swing direction, toggles at each apex
  motorPwm  out  1  motor enable, duty = amp/16
  apex  out  1  one-clk pulse at each swing turnaround
  Flow  out  1  high while amp is non-zero
  halfPeriod  out  8  current half-period in ticks
  amp  out  4  current amplitude 0..15
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low, named reset.

Function
REQ-004 A prescaler SHALL count clk cycles 0..PRESCALE-1 and emit an internal tick on the cycle it equals PRESCALE-1, then wrap to 0.
REQ-005 A swing counter SHALL advance on each tick, 0..halfPeriod-1; on the tick where it equals halfPeriod-1 it SHALL wrap to 0 and that clock edge is the apex edge.
REQ-006 At the apex edge motorDir SHALL toggle and apex SHALL be high for exactly the following clk cycle.
REQ-007 Fplus, Fmin, Amin SHALL be sampled only at the apex edge; their values at all other edges SHALL have no effect.
REQ-008 At the apex edge, Fplus=1 with Fmin=0: halfPeriod SHALL become max(halfPeriod-HP_STEP, HP_MIN); Fmin=1 with Fplus=0: min(halfPeriod+HP_STEP, HP_MAX); both or neither: unchanged.
REQ-009 At the apex edge, Amin=1 SHALL decrement amp by 1, saturating at 0.
REQ-010 A new halfPeriod SHALL govern the next half-swing; the swing counter SHALL restart from 0 regardless.
REQ-011 start=1 SHALL on that edge load amp=AMP_INIT, swing counter=0, prescaler=0, motorDir=0, suppress apex, and override any simultaneous apex commands; halfPeriod is retained.
REQ-012 A free-running 4-bit PWM counter SHALL increment every clk; motorPwm SHALL be 1 exactly when counter < amp (amp=0 gives 0; amp=15 gives 15/16).
REQ-013 With amp=0 the prescaler, swing counter, motorDir, apex and frequency commands SHALL keep operating; only motorPwm and Flow are held low.
REQ-014 Flow SHALL equal (amp != 0) combinationally from the amp register.
REQ-015 Intermediate halfPeriod arithmetic SHALL be at least 9 bits so HP_MAX+HP_STEP and HP_MIN-HP_STEP never wrap before saturation.

Reset
REQ-016 While reset=0: halfPeriod=HP_INIT, amp=0, motorDir=0, apex=0, motorPwm=0, Flow=0, all counters=0.
REQ-017 Reset assertion mid-swing SHALL take effect immediately without a clock; after release the first tick SHALL occur PRESCALE cycles later.

Verification (PRESCALE=2, HP_INIT=4, HP_MIN=2, HP_MAX=6, HP_STEP=2, AMP_INIT=3)
REQ-018 Release reset, pulse start -> Flow=1, amp=3; apex every 8 clk; motorDir toggles each apex; motorPwm high 3 of every 16 clk.
REQ-019 Hold Fplus=1 across two apexes -> halfPeriod 4->2->2 (saturates); apex spacing 8->4 clk.
REQ-020 Hold Fmin=1 across three apexes -> halfPeriod 4->6->6; Fplus=Fmin=1 at an apex -> unchanged.
REQ-021 Pulse Amin away from apex -> amp unchanged; hold Amin across four apexes -> amp 3,2,1,0,0; Flow and motorPwm fall with amp=0 while apex continues.
REQ-022 start coincident with apex and Amin=1 -> amp=3, no apex pulse, motorDir=0, counters restart.
REQ-023 Drop reset mid-swing with amp=2, halfPeriod=6 -> outputs return to REQ-016 values asynchronously.
